// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: instruction-memory, redirect and decode handshake bundle of the fetch unit
interface ifetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch with credit-limited issue, prefetch FIFO and redirect flush
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst_n,
    ifetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [31:0]   fetch_pc, resp_pc;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, o, drop;
    logic [CW:0]   credit;
    logic          issue, push, pop;

    // Issue is gated by reset so the request drops the instant reset asserts;
    // queued plus outstanding requests never exceed DEPTH, so a push always has room
    always_comb begin
        credit       = {1'b0, count} + {1'b0, o};
        bus.imem_req = rst_n && !bus.redirect_valid && (credit < (CW+1)'(DEPTH));
        bus.imem_addr = fetch_pc;
        issue        = bus.imem_req && bus.imem_gnt;
        push         = bus.imem_rvalid && !bus.redirect_valid && (drop == '0);
        bus.if_valid = (count != '0) && !bus.redirect_valid;
        pop          = bus.if_valid && bus.id_ready;
        bus.if_instr = bus.if_valid ? instr_q[rd_ptr] : 32'h0000_0013;
        bus.if_pc    = bus.if_valid ? pc_q[rd_ptr] : 32'h0;
    end

    // FIFO storage needs no reset: entries are only read while count says they are valid
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= bus.imem_rdata;
            pc_q[wr_ptr]    <= resp_pc;
        end
    end

    // Fetch/response PCs, FIFO pointers and the in-flight bookkeeping; redirect overrides all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC & ~32'h3;
            resp_pc  <= RESET_PC & ~32'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            o        <= '0;
            drop     <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc & ~32'h3;
            resp_pc  <= bus.redirect_pc & ~32'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            o        <= o - CW'(bus.imem_rvalid);
            drop     <= o - CW'(bus.imem_rvalid);
        end else begin
            fetch_pc <= issue ? fetch_pc + 32'd4 : fetch_pc;
            resp_pc  <= push ? resp_pc + 32'd4 : resp_pc;
            rd_ptr   <= rd_ptr + AW'(pop);
            wr_ptr   <= wr_ptr + AW'(push);
            count    <= count + CW'(push) - CW'(pop);
            o        <= o + CW'(issue) - CW'(bus.imem_rvalid);
            drop     <= (bus.imem_rvalid && drop != '0) ? drop - ONE : drop;
        end
    end

    // A push into a full FIFO would mean the credit accounting is broken
    assert property (@(posedge clk) disable iff (!rst_n) !(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized bench against a queue-based reference model of the fetch unit
module tb_ifetch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        bit          doomed;
        int          rdy;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ifetch_queue_if bus();

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    req_t        pend[$];
    logic [31:0] fifo[$];
    logic [31:0] fpc;
    int          last_rdy;
    int          cyc;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
    endtask

    task automatic model_reset();
        pend.delete();
        fifo.delete();
        fpc      = 32'h0;
        last_rdy = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(bus.imem_req), 32'h0);
        chk({tag, "_valid"}, 32'(bus.if_valid), 32'h0);
        chk({tag, "_instr"}, bus.if_instr, 32'h0000_0013);
        chk({tag, "_pc"},    bus.if_pc, 32'h0);
        chk({tag, "_addr"},  bus.imem_addr, 32'h0);
    endtask

    task automatic run_phase(input int n, input int p_gnt, input int p_rdy,
                             input int max_lat, input int p_redir);
        for (int k = 0; k < n; k++) begin
            logic        redir, gnt, rdy, rv, exp_req, exp_valid;
            logic [31:0] rpc;
            int          lat, r;
            req_t        e;
            @(negedge clk);
            redir = ($urandom_range(99) < p_redir);
            rpc   = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC + $urandom_range(3) : $urandom;
            gnt   = ($urandom_range(99) < p_gnt);
            rdy   = ($urandom_range(99) < p_rdy);
            rv    = (pend.size() > 0) && (pend[0].rdy <= cyc);
            bus.redirect_valid = redir;
            bus.redirect_pc    = rpc;
            bus.imem_gnt       = gnt;
            bus.id_ready       = rdy;
            bus.imem_rvalid    = rv;
            bus.imem_rdata     = rv ? word(pend[0].a) : 32'hDEAD_BEEF;
            #1;
            exp_req   = !redir && (fifo.size() + pend.size() < DEPTH);
            exp_valid = (fifo.size() != 0) && !redir;
            chk("imem_req",  32'(bus.imem_req), 32'(exp_req));
            chk("imem_addr", bus.imem_addr, fpc);
            chk("if_valid",  32'(bus.if_valid), 32'(exp_valid));
            chk("if_instr",  bus.if_instr, exp_valid ? word(fifo[0]) : 32'h0000_0013);
            chk("if_pc",     bus.if_pc, exp_valid ? fifo[0] : 32'h0);
            if (exp_req && gnt) begin
                lat = $urandom_range(max_lat, 1);
                r   = (cyc + lat > last_rdy + 1) ? cyc + lat : last_rdy + 1;
                last_rdy = r;
                pend.push_back('{a: fpc, doomed: 1'b0, rdy: r});
                fpc = fpc + 32'd4;
            end
            if (exp_valid && rdy) void'(fifo.pop_front());
            if (rv) begin
                e = pend.pop_front();
                if (!redir && !e.doomed) fifo.push_back(e.a);
            end
            if (redir) begin
                fifo.delete();
                foreach (pend[i]) pend[i].doomed = 1'b1;
                fpc = rpc & ~32'h3;
            end
            cyc++;
        end
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs(tag);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        cyc = 0;
        idle_inputs();
        model_reset();
        #2 chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_phase(200, 100, 100, 1, 0);
        run_phase(200, 100, 10,  1, 0);
        run_phase(300, 30,  70,  3, 5);
        run_phase(300, 100, 100, 3, 15);
        async_reset("async_rst");
        run_phase(300, 80,  50,  4, 30);
        run_phase(300, 100, 100, 1, 10);
        async_reset("async_rst2");
        run_phase(100, 100, 100, 2, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
